// File: rtl/iob_uart16550_ctrl.sv
// IOb-bus master that initialises a uart16550 and then moves TX/RX bytes by polling LSR.
module iob_uart16550_ctrl #(
    parameter logic [15:0] DIV     = 16'd27,
    parameter logic [7:0]  LCR_CFG = 8'h03,
    parameter logic [7:0]  FCR_CFG = 8'h07
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        restart_i,
    output logic        done_o,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_err_o,
    input  logic        rx_ready_i,
    output logic        iob_avalid_o,
    output logic [2:0]  iob_addr_o,
    output logic [31:0] iob_wdata_o,
    output logic [3:0]  iob_wstrb_o,
    input  logic        iob_ready_i,
    input  logic        iob_rvalid_i,
    input  logic [31:0] iob_rdata_i
);

    localparam logic [2:0] AddrRbr = 3'd0;
    localparam logic [2:0] AddrLsr = 3'd5;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLsrRd,
        StLsrWait,
        StThrWr,
        StRbrRd,
        StRbrWait
    } state_e;

    state_e      state_q;
    logic [2:0]  step_q;
    logic        prio_q;    // 1: RX is favoured at the next tie
    logic        cls_tx_q;  // LSR poll in flight belongs to the TX path
    logic        err_q;
    logic        avalid_q;
    logic [2:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        done_q;
    logic        rx_valid_q;
    logic [7:0]  rx_data_q;
    logic        rx_err_q;

    logic [10:0] init_cur;
    logic [10:0] init_nxt;
    logic [7:0]  rd_byte;
    logic        tx_req;
    logic        rx_req;
    logic        pick_tx;

    // Init write table entry: {addr, data}.
    function automatic logic [10:0] init_wr(input logic [2:0] idx);
        case (idx)
            3'd0:    return {3'd3, 8'h80 | LCR_CFG};
            3'd1:    return {3'd0, DIV[7:0]};
            3'd2:    return {3'd1, DIV[15:8]};
            3'd3:    return {3'd3, LCR_CFG};
            3'd4:    return {3'd2, FCR_CFG};
            default: return {3'd1, 8'h00};
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [2:0] addr);
        return 4'b0001 << addr[1:0];
    endfunction

    // Decode init table, read lane and arbitration request.
    always_comb begin
        init_cur = init_wr(step_q);
        init_nxt = init_wr(step_q + 3'd1);
        rd_byte  = iob_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        tx_req   = tx_valid_i;
        rx_req   = ~rx_valid_q;
        pick_tx  = tx_req & (~rx_req | ~prio_q);
    end

    // Sequencer FSM with registered bus and stream outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= StInit;
            step_q     <= 3'd0;
            prio_q     <= 1'b0;
            cls_tx_q   <= 1'b0;
            err_q      <= 1'b0;
            avalid_q   <= 1'b0;
            addr_q     <= 3'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_err_q   <= 1'b0;
        end else begin
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
            unique case (state_q)
                StInit: begin
                    if (!avalid_q) begin
                        avalid_q <= 1'b1;
                        addr_q   <= init_cur[10:8];
                        wdata_q  <= {4{init_cur[7:0]}};
                        wstrb_q  <= lane_strb(init_cur[10:8]);
                    end else if (iob_ready_i) begin
                        if (step_q == 3'd5) begin
                            avalid_q <= 1'b0;
                            wstrb_q  <= 4'd0;
                            done_q   <= 1'b1;
                            state_q  <= StIdle;
                        end else begin
                            step_q   <= step_q + 3'd1;
                            addr_q   <= init_nxt[10:8];
                            wdata_q  <= {4{init_nxt[7:0]}};
                            wstrb_q  <= lane_strb(init_nxt[10:8]);
                        end
                    end
                end
                StIdle: begin
                    if (restart_i) begin
                        done_q  <= 1'b0;
                        step_q  <= 3'd0;
                        state_q <= StInit;
                    end else if (tx_req || rx_req) begin
                        cls_tx_q <= pick_tx;
                        prio_q   <= pick_tx;
                        avalid_q <= 1'b1;
                        addr_q   <= AddrLsr;
                        wstrb_q  <= 4'd0;
                        state_q  <= StLsrRd;
                    end
                end
                StLsrRd: begin
                    if (iob_ready_i) begin
                        avalid_q <= 1'b0;
                        state_q  <= StLsrWait;
                    end
                end
                StLsrWait: begin
                    if (iob_rvalid_i) begin
                        if (cls_tx_q) begin
                            // Re-check tx_valid_i so a withdrawn byte is never written.
                            if (rd_byte[5] && tx_valid_i) begin
                                avalid_q <= 1'b1;
                                addr_q   <= AddrRbr;
                                wdata_q  <= {4{tx_data_i}};
                                wstrb_q  <= 4'b0001;
                                state_q  <= StThrWr;
                            end else begin
                                state_q  <= StIdle;
                            end
                        end else if (rd_byte[0]) begin
                            err_q    <= |rd_byte[4:1];
                            avalid_q <= 1'b1;
                            addr_q   <= AddrRbr;
                            wstrb_q  <= 4'd0;
                            state_q  <= StRbrRd;
                        end else begin
                            state_q  <= StIdle;
                        end
                    end
                end
                StThrWr: begin
                    if (iob_ready_i) begin
                        avalid_q <= 1'b0;
                        wstrb_q  <= 4'd0;
                        state_q  <= StIdle;
                    end
                end
                StRbrRd: begin
                    if (iob_ready_i) begin
                        avalid_q <= 1'b0;
                        state_q  <= StRbrWait;
                    end
                end
                StRbrWait: begin
                    if (iob_rvalid_i) begin
                        rx_data_q  <= rd_byte;
                        rx_err_q   <= err_q;
                        rx_valid_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // Output mapping; tx_ready_o marks the accepting cycle of the THR write.
    always_comb begin
        done_o       = done_q;
        tx_ready_o   = (state_q == StThrWr) & avalid_q & iob_ready_i;
        rx_valid_o   = rx_valid_q;
        rx_data_o    = rx_data_q;
        rx_err_o     = rx_err_q;
        iob_avalid_o = avalid_q;
        iob_addr_o   = addr_q;
        iob_wdata_o  = wdata_q;
        iob_wstrb_o  = wstrb_q;
    end

endmodule

// File: tb/tb_iob_uart16550_ctrl.sv
// Directed bench for iob_uart16550_ctrl with a behavioural UART slave and bus log.
module tb_iob_uart16550_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        restart_i;
    logic        done_o;
    logic        tx_valid_i;
    logic [7:0]  tx_data_i;
    logic        tx_ready_o;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        rx_err_o;
    logic        rx_ready_i;
    logic        iob_avalid_o;
    logic [2:0]  iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_ready_i = 1'b1;
    logic        iob_rvalid_i;
    logic [31:0] iob_rdata_i;

    typedef struct packed {
        logic [2:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
    } txn_t;

    txn_t        log_q[$];
    int          tx_cnt  = 0;
    int          rbr_cnt = 0;
    int          total   = 0;
    int          bad     = 0;
    int          stall_cnt = 0;
    logic        stall_dll;
    logic [7:0]  lsr_val;
    logic [7:0]  rbr_val;

    iob_uart16550_ctrl dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .restart_i   (restart_i),
        .done_o      (done_o),
        .tx_valid_i  (tx_valid_i),
        .tx_data_i   (tx_data_i),
        .tx_ready_o  (tx_ready_o),
        .rx_valid_o  (rx_valid_o),
        .rx_data_o   (rx_data_o),
        .rx_err_o    (rx_err_o),
        .rx_ready_i  (rx_ready_i),
        .iob_avalid_o(iob_avalid_o),
        .iob_addr_o  (iob_addr_o),
        .iob_wdata_o (iob_wdata_o),
        .iob_wstrb_o (iob_wstrb_o),
        .iob_ready_i (iob_ready_i),
        .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i (iob_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_put(input logic [2:0] a, input logic [7:0] b);
        logic [31:0] r;
        r = 32'hEEEE_EEEE;
        r[8*int'(a[1:0]) +: 8] = b;
        return r;
    endfunction

    function automatic txn_t get_txn(input int i);
        txn_t t;
        t = '{a: 3'd7, s: 4'hF, d: 32'd0};
        if (i >= 0 && i < log_q.size()) t = log_q[i];
        return t;
    endfunction

    // Slave: rvalid one cycle after an accepted read, byte on lane addr[1:0].
    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            iob_rvalid_i <= 1'b0;
            iob_rdata_i  <= 32'd0;
        end else if (iob_avalid_o && iob_ready_i && iob_wstrb_o == 4'd0) begin
            iob_rvalid_i <= 1'b1;
            iob_rdata_i  <= lane_put(iob_addr_o, (iob_addr_o == 3'd5) ? lsr_val : rbr_val);
        end else begin
            iob_rvalid_i <= 1'b0;
        end
    end

    // Monitor: log accepted bus transfers and TX hand-offs.
    always @(posedge clk_i) begin
        if (rst_n_i && iob_avalid_o && iob_ready_i) begin
            log_q.push_back('{a: iob_addr_o, s: iob_wstrb_o, d: iob_wdata_o});
            if (iob_addr_o == 3'd0 && iob_wstrb_o == 4'd0) rbr_cnt++;
        end
        if (rst_n_i && tx_ready_o) tx_cnt++;
    end

    // Slave ready: optionally stall the DLL init write for three cycles.
    always @(negedge clk_i) begin
        if (!stall_dll) begin
            stall_cnt = 0;
            iob_ready_i = 1'b1;
        end else if (iob_avalid_o && iob_addr_o == 3'd0 && !done_o && stall_cnt < 3) begin
            stall_cnt++;
            iob_ready_i = 1'b0;
        end else begin
            iob_ready_i = 1'b1;
        end
    end

    task automatic wait_done(output int dll_hold);
        dll_hold = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (iob_avalid_o && iob_addr_o == 3'd0 && iob_wdata_o == 32'h1B1B_1B1B && !done_o)
                dll_hold++;
            if (done_o) break;
        end
        check("init_done", done_o, 1'b1);
    endtask

    task automatic check_init(input int base, input string tag);
        logic [2:0]  ea[6] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
        logic [7:0]  ed[6] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};
        logic [3:0]  es[6] = '{4'h8, 4'h1, 4'h2, 4'h8, 4'h4, 4'h2};
        int          idx;
        txn_t        t;
        idx = base;
        while (idx < log_q.size() && log_q[idx].s == 4'd0) idx++;
        for (int k = 0; k < 6; k++) begin
            t = get_txn(idx + k);
            check($sformatf("%s_addr%0d", tag, k), {29'd0, t.a}, {29'd0, ea[k]});
            check($sformatf("%s_strb%0d", tag, k), {28'd0, t.s}, {28'd0, es[k]});
            check($sformatf("%s_data%0d", tag, k), t.d, {4{ed[k]}});
        end
    endtask

    task automatic wait_rx_valid();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (rx_valid_o) break;
        end
        check("rx_valid_seen", rx_valid_o, 1'b1);
    endtask

    initial begin
        int   base;
        int   hold;
        int   snap;
        int   nwr;
        int   nrd;
        int   idx;
        int   alt_bad;
        logic f;
        logic prev;
        txn_t t;

        rst_n_i = 1'b0; restart_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = 8'h00;
        rx_ready_i = 1'b0; lsr_val = 8'h00; rbr_val = 8'h00; stall_dll = 1'b0;
        prev = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_avalid", iob_avalid_o, 1'b0);
        check("rst_addr", {29'd0, iob_addr_o}, 32'd0);
        check("rst_wdata", iob_wdata_o, 32'd0);
        check("rst_wstrb", {28'd0, iob_wstrb_o}, 32'd0);
        check("rst_done", done_o, 1'b0);
        check("rst_txrdy", tx_ready_o, 1'b0);
        check("rst_rxv", rx_valid_o, 1'b0);
        check("rst_rxd", {24'd0, rx_data_o}, 32'd0);
        check("rst_rxerr", rx_err_o, 1'b0);

        // Init with zero-wait slave
        base = log_q.size();
        rst_n_i = 1'b1;
        wait_done(hold);
        check_init(base, "init");

        // Init with DLL write stalled for three cycles
        rst_n_i = 1'b0;
        stall_dll = 1'b1;
        repeat (2) @(negedge clk_i);
        base = log_q.size();
        rst_n_i = 1'b1;
        wait_done(hold);
        check("dll_hold_cycles", hold, 4);
        check_init(base, "stall");
        stall_dll = 1'b0;

        // TX with THRE set
        lsr_val = 8'h60; tx_data_i = 8'h41; tx_valid_i = 1'b1;
        snap = tx_cnt; base = log_q.size();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (tx_cnt != snap) break;
        end
        tx_valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("tx_pulse_once", tx_cnt - snap, 1);
        nwr = 0; idx = -1;
        for (int i = base; i < log_q.size(); i++) begin
            if (log_q[i].s != 4'd0) begin
                nwr++;
                if (idx < 0) idx = i;
            end
        end
        check("tx_thr_writes", nwr, 1);
        t = get_txn(idx);
        check("tx_thr_addr", {29'd0, t.a}, 32'd0);
        check("tx_thr_strb", {28'd0, t.s}, 32'd1);
        check("tx_thr_data", t.d, 32'h4141_4141);
        t = get_txn(idx - 1);
        check("tx_lsr_addr", {29'd0, t.a}, 32'd5);
        check("tx_lsr_read", {28'd0, t.s}, 32'd0);

        // TX with THRE clear: no write, LSR keeps being polled
        lsr_val = 8'h00; tx_data_i = 8'h42; tx_valid_i = 1'b1;
        snap = tx_cnt; base = log_q.size();
        repeat (40) @(negedge clk_i);
        tx_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        nwr = 0; nrd = 0;
        for (int i = base; i < log_q.size(); i++) begin
            if (log_q[i].s != 4'd0) nwr++;
            if (log_q[i].s == 4'd0 && log_q[i].a == 3'd5) nrd++;
        end
        check("tx_nothre_nowr", nwr, 0);
        check("tx_nothre_repoll", (nrd >= 4) ? 1 : 0, 1);
        check("tx_nothre_nordy", tx_cnt - snap, 0);

        // RX byte held while consumer stalls
        lsr_val = 8'h01; rbr_val = 8'h5A; rx_ready_i = 1'b0;
        wait_rx_valid();
        check("rx_data", {24'd0, rx_data_o}, 32'h5A);
        check("rx_err_clean", rx_err_o, 1'b0);
        base = log_q.size();
        repeat (20) @(negedge clk_i);
        check("rx_no_poll", log_q.size() - base, 0);
        check("rx_hold_valid", rx_valid_o, 1'b1);
        check("rx_hold_data", {24'd0, rx_data_o}, 32'h5A);
        lsr_val = 8'h00; rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
        check("rx_accept_clr", rx_valid_o, 1'b0);

        // RX byte with framing error
        lsr_val = 8'h09; rbr_val = 8'h00;
        wait_rx_valid();
        check("rxe_err", rx_err_o, 1'b1);
        check("rxe_data", {24'd0, rx_data_o}, 32'h00);
        lsr_val = 8'h00; rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
        check("rxe_accept_clr", rx_valid_o, 1'b0);

        // Both classes pending: LSR polls alternate TX / RX
        lsr_val = 8'h20; tx_data_i = 8'h33; tx_valid_i = 1'b1;
        base = log_q.size();
        repeat (80) @(negedge clk_i);
        tx_valid_i = 1'b0;
        lsr_val = 8'h00;
        repeat (5) @(negedge clk_i);
        nrd = 0; alt_bad = 0;
        for (int i = base; i < log_q.size() - 1; i++) begin
            if (log_q[i].s == 4'd0 && log_q[i].a == 3'd5) begin
                f = (log_q[i+1].s == 4'd1 && log_q[i+1].a == 3'd0);
                if (nrd > 0 && f == prev) alt_bad++;
                prev = f;
                nrd++;
            end
        end
        check("arb_polls", (nrd >= 8) ? 1 : 0, 1);
        check("arb_alternate", alt_bad, 0);

        // Restart from IDLE reruns init
        base = log_q.size();
        restart_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (!done_o) break;
        end
        restart_i = 1'b0;
        check("restart_done_clr", done_o, 1'b0);
        wait_done(hold);
        check_init(base, "restart");

        // Reset while waiting for RBR data
        lsr_val = 8'h01; rbr_val = 8'h77; rx_ready_i = 1'b0;
        snap = rbr_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (rbr_cnt != snap) break;
        end
        check("rbr_read_seen", (rbr_cnt != snap) ? 1 : 0, 1);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check("rrst_avalid", iob_avalid_o, 1'b0);
        check("rrst_wstrb", {28'd0, iob_wstrb_o}, 32'd0);
        check("rrst_addr", {29'd0, iob_addr_o}, 32'd0);
        check("rrst_wdata", iob_wdata_o, 32'd0);
        check("rrst_done", done_o, 1'b0);
        check("rrst_rxv", rx_valid_o, 1'b0);
        check("rrst_rxd", {24'd0, rx_data_o}, 32'd0);
        check("rrst_rxerr", rx_err_o, 1'b0);
        check("rrst_txrdy", tx_ready_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
